// File: rtl/timer_pkg.sv
// Shared timing-infrastructure package for timer and tick_interval_meter.
// Holds the meter state encoding and the ns-conversion saturation helper.
`timescale 1ns/1ps
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FIRST = 2'd1,
    ST_MEASURE    = 2'd2
  } meter_state_t;

  localparam int unsigned NS_CALC_WIDTH = 64;

  // Clamp a wide cycles*period product to the all-ones value of a narrower result field.
  function automatic logic [NS_CALC_WIDTH-1:0] nsSaturate(
    input logic [NS_CALC_WIDTH-1:0] product,
    input int unsigned              width
  );
    logic [NS_CALC_WIDTH-1:0] limit;
    logic [NS_CALC_WIDTH-1:0] result;
    result = product;
    if (width < NS_CALC_WIDTH) begin
      limit = (64'd1 << width) - 64'd1;
      if (product > limit) begin
        result = limit;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for the tick input of tick_interval_meter.
// Define TICK_METER_SYNC_EN to put a 2-flop synchroniser in front of the
// detector so tick_in may be asynchronous to the clock (+2 cycles latency).
`timescale 1ns/1ps
module tick_edge_detect (
  input  logic i_clk,
  input  logic i_sync_reset,
  input  logic i_enable,
  input  logic i_tick,
  output logic o_edge
);

  logic w_tick;
  logic r_tickQ;

`ifdef TICK_METER_SYNC_EN
  logic [1:0] r_sync;

  // Two-stage synchroniser; frozen with the rest of the block when disabled.
  always_ff @(posedge i_clk) begin
    if (i_sync_reset) begin
      r_sync <= 2'b00;
    end else if (i_enable) begin
      r_sync <= {r_sync[0], i_tick};
    end
  end

  assign w_tick = r_sync[1];
`else
  assign w_tick = i_tick;
`endif

  // Previous tick level; held while disabled so re-enable compares against the frozen value.
  always_ff @(posedge i_clk) begin
    if (i_sync_reset) begin
      r_tickQ <= 1'b0;
    end else if (i_enable) begin
      r_tickQ <= w_tick;
    end
  end

  assign o_edge = w_tick & ~r_tickQ;

endmodule

// File: rtl/tick_interval_meter.sv
// Measures rising-edge-to-rising-edge spacing of tick_in in clock cycles and ns.
// Optional TICK_METER_SYNC_EN adds an input synchroniser inside tick_edge_detect.
`timescale 1ns/1ps
module tick_interval_meter
  import timer_pkg::*;
#(
  parameter int unsigned CLK_PERIOD_ns = 20,
  parameter int unsigned COUNT_WIDTH   = 24,
  parameter int unsigned NS_WIDTH      = 32
) (
  input  logic                   i_clk,
  input  logic                   i_sync_reset,
  input  logic                   i_enable,
  input  logic                   i_arm,
  input  logic                   i_tick_in,
  output logic                   o_busy,
  output logic                   o_interval_valid,
  output logic [COUNT_WIDTH-1:0] o_interval_cycles,
  output logic [NS_WIDTH-1:0]    o_interval_ns,
  output logic                   o_overflow
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  meter_state_t r_state;
  meter_state_t w_stateNext;
  logic         w_busy;

  logic                     w_edge;
  logic                     w_capture;
  logic                     w_cntFull;
  logic [COUNT_WIDTH-1:0]   r_cnt;
  logic [COUNT_WIDTH-1:0]   w_captureCycles;
  logic [NS_CALC_WIDTH-1:0] w_nsProduct;

  logic                   r_intervalValid;
  logic [COUNT_WIDTH-1:0] r_intervalCycles;
  logic [NS_WIDTH-1:0]    r_intervalNs;
  logic                   r_overflow;

  tick_edge_detect u_edgeDetect (
    .i_clk        (i_clk),
    .i_sync_reset (i_sync_reset),
    .i_enable     (i_enable),
    .i_tick       (i_tick_in),
    .o_edge       (w_edge)
  );

  // State register; reset wins over enable, disabled cycles freeze the state.
  always_ff @(posedge i_clk) begin
    if (i_sync_reset) begin
      r_state <= ST_IDLE;
    end else if (i_enable) begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic; dropping arm never aborts, it only stops the next interval from starting.
  always_comb begin
    w_stateNext = r_state;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_arm) begin
          w_stateNext = ST_WAIT_FIRST;
        end
      end
      ST_WAIT_FIRST: begin
        w_busy = 1'b1;
        if (w_edge) begin
          w_stateNext = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        w_busy = 1'b1;
        if (w_edge && !i_arm) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  assign w_cntFull       = (r_cnt == CNT_MAX);
  assign w_captureCycles = w_cntFull ? CNT_MAX : (r_cnt + COUNT_WIDTH'(1));
  assign w_capture       = (r_state == ST_MEASURE) && w_edge;
  assign w_nsProduct     = NS_CALC_WIDTH'(w_captureCycles) * NS_CALC_WIDTH'(CLK_PERIOD_ns);

  // Cycle counter: cleared by every opening/closing edge, saturating in between.
  always_ff @(posedge i_clk) begin
    if (i_sync_reset) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      case (r_state)
        ST_WAIT_FIRST: begin
          if (w_edge) begin
            r_cnt <= '0;
          end
        end
        ST_MEASURE: begin
          if (w_edge) begin
            r_cnt <= '0;
          end else if (!w_cntFull) begin
            r_cnt <= r_cnt + COUNT_WIDTH'(1);
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Result registers: one-cycle strobe, results held until the next capture.
  always_ff @(posedge i_clk) begin
    if (i_sync_reset) begin
      r_intervalValid  <= 1'b0;
      r_intervalCycles <= '0;
      r_intervalNs     <= '0;
      r_overflow       <= 1'b0;
    end else begin
      r_intervalValid <= i_enable && w_capture;
      if (i_enable && w_capture) begin
        r_intervalCycles <= w_captureCycles;
        r_intervalNs     <= NS_WIDTH'(nsSaturate(w_nsProduct, NS_WIDTH));
        r_overflow       <= w_cntFull;
      end
    end
  end

  assign o_busy            = w_busy;
  assign o_interval_valid  = r_intervalValid;
  assign o_interval_cycles = r_intervalCycles;
  assign o_interval_ns     = r_intervalNs;
  assign o_overflow        = r_overflow;

endmodule

// File: tb/tb_tick_interval_meter.sv
// Scoreboard testbench for tick_interval_meter (small COUNT_WIDTH/NS_WIDTH so
// counter and ns saturation are reachable). Honors TICK_METER_SYNC_EN.
`timescale 1ns/1ps
module tb_tick_interval_meter;

  localparam int unsigned CLK_NS = 20;
  localparam int unsigned CW     = 5;
  localparam int unsigned NSW    = 9;
`ifdef TICK_METER_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  typedef struct {
    int cycles;
    int ns;
    bit ovf;
    bit busy;
    int atCyc;
  } exp_t;

  logic          i_clk = 1'b0;
  logic          i_sync_reset;
  logic          i_enable;
  logic          i_arm;
  logic          i_tick_in;
  logic          o_busy;
  logic          o_interval_valid;
  logic [CW-1:0] o_interval_cycles;
  logic [NSW-1:0] o_interval_ns;
  logic          o_overflow;

  int   nChecks = 0;
  int   nFail   = 0;
  int   cyc     = 0;
  exp_t sbq[$];
  exp_t monE;
  exp_t lastE;
  int   plan[$];

  tick_interval_meter #(
    .CLK_PERIOD_ns (CLK_NS),
    .COUNT_WIDTH   (CW),
    .NS_WIDTH      (NSW)
  ) dut (
    .i_clk             (i_clk),
    .i_sync_reset      (i_sync_reset),
    .i_enable          (i_enable),
    .i_arm             (i_arm),
    .i_tick_in         (i_tick_in),
    .o_busy            (o_busy),
    .o_interval_valid  (o_interval_valid),
    .o_interval_cycles (o_interval_cycles),
    .o_interval_ns     (o_interval_ns),
    .o_overflow        (o_overflow)
  );

  always #(CLK_NS / 2) i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nChecks++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s: actual %0d, required %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: K cycles between rises gives K, clamped to the counter range; overflow once K exceeds it.
  function automatic exp_t model(input int k, input int atCyc, input bit busyAfter);
    exp_t e;
    int   maxCnt;
    int   maxNs;
    maxCnt   = (1 << CW) - 1;
    maxNs    = (1 << NSW) - 1;
    e.cycles = (k > maxCnt) ? maxCnt : k;
    e.ovf    = (k > maxCnt);
    e.ns     = (e.cycles * CLK_NS > maxNs) ? maxNs : e.cycles * CLK_NS;
    e.busy   = busyAfter;
    e.atCyc  = atCyc;
    return e;
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge i_clk) begin
    if (o_interval_valid) begin
      if (sbq.size() == 0) begin
        nChecks++;
        nFail++;
        $display("[TB] FAIL unexpected_strobe: actual strobe with cycles=%0d, required no strobe (cycle %0d)",
                 o_interval_cycles, cyc);
      end else begin
        monE = sbq.pop_front();
        checkOutput("strobe_cycles", longint'(o_interval_cycles), longint'(monE.cycles));
        checkOutput("strobe_ns", longint'(o_interval_ns), longint'(monE.ns));
        checkOutput("strobe_overflow", longint'(o_overflow), longint'(monE.ovf));
        checkOutput("strobe_busy", longint'(o_busy), longint'(monE.busy));
        checkOutput("strobe_latency_cycle", longint'(cyc), longint'(monE.atCyc));
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, longint'(o_busy), 0);
    checkOutput({tag, "_valid"}, longint'(o_interval_valid), 0);
    checkOutput({tag, "_cycles"}, longint'(o_interval_cycles), 0);
    checkOutput({tag, "_ns"}, longint'(o_interval_ns), 0);
    checkOutput({tag, "_overflow"}, longint'(o_overflow), 0);
  endtask

  task automatic checkHeld();
    checkOutput("hold_cycles", longint'(o_interval_cycles), longint'(lastE.cycles));
    checkOutput("hold_ns", longint'(o_interval_ns), longint'(lastE.ns));
    checkOutput("hold_overflow", longint'(o_overflow), longint'(lastE.ovf));
  endtask

  task automatic holdFor(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  // Drives one measurement run from plan[]: N intervals need N+1 ticks (1-cycle pulses).
  // Single shot expects only the first interval; free run expects all of them.
  // Optional freeze adds 3 disabled cycles early in the first interval, optionally with a hidden tick pulse.
  task automatic applyStimulus(input bit freeRun, input bit doFreeze, input bit glitch);
    int rise[$];
    int n;
    int len;
    int armDrop;
    int t;
    n = plan.size();
    rise.push_back(0);
    for (int i = 0; i < n; i++) rise.push_back(rise[i] + plan[i]);
    len     = rise[n] + SYNC_LAT + 6;
    armDrop = freeRun ? rise[n-1] + SYNC_LAT + 1 : 0;

    i_arm = 1'b1;
    @(negedge i_clk);
    checkOutput("busy_after_arm", longint'(o_busy), 1);
    i_arm = freeRun;
    holdFor(2);

    t = 0;
    for (int k = 0; k < len; k++) begin
      if (doFreeze && k == 2) begin
        i_enable = 1'b0;
        i_tick_in = glitch;
        @(negedge i_clk);
        i_tick_in = 1'b0;
        holdFor(2);
        i_enable = 1'b1;
      end
      i_arm = freeRun && (k < armDrop);
      i_tick_in = 1'b0;
      if (t <= n && k == rise[t]) begin
        i_tick_in = 1'b1;
        if (t >= 1 && (freeRun || t == 1)) begin
          lastE = model(plan[t-1], cyc + 1 + SYNC_LAT, freeRun && (t < n));
          sbq.push_back(lastE);
        end
        t++;
      end
      @(negedge i_clk);
    end
    i_tick_in = 1'b0;
    i_arm = 1'b0;
    checkOutput("busy_idle_after_run", longint'(o_busy), 0);
    checkHeld();
  endtask

  initial begin
    i_sync_reset = 1'b1;
    i_enable     = 1'b1;
    i_arm        = 1'b0;
    i_tick_in    = 1'b0;
    lastE        = model(0, 0, 1'b0);
    holdFor(3);
    checkResetState("reset");
    i_sync_reset = 1'b0;

    $display("[TB] single shot, ticks 5 apart");
    plan = '{5, 5, 5};
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] free run, ticks 5 apart");
    plan = '{5, 5, 5};
    applyStimulus(1'b1, 1'b0, 1'b0);

    $display("[TB] boundaries: minimum interval, counter and ns saturation");
    plan = '{2, 2, 25, 26, 31, 32, 40, 3};
    applyStimulus(1'b1, 1'b0, 1'b0);
    plan = '{40};
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] enable freeze mid-measurement");
    plan = '{5, 5};
    applyStimulus(1'b1, 1'b1, 1'b0);
    plan = '{5};
    applyStimulus(1'b0, 1'b1, 1'b1);

    $display("[TB] reset mid-measurement (reset with enable low)");
    i_arm = 1'b1;
    @(negedge i_clk);
    i_arm = 1'b0;
    @(negedge i_clk);
    i_tick_in = 1'b1;
    @(negedge i_clk);
    i_tick_in = 1'b0;
    @(negedge i_clk);
    i_sync_reset = 1'b1;
    i_enable     = 1'b0;
    @(negedge i_clk);
    i_sync_reset = 1'b0;
    i_enable     = 1'b1;
    checkResetState("midreset");
    lastE = model(0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      i_tick_in = 1'b1;
      @(negedge i_clk);
      i_tick_in = 1'b0;
      holdFor(4);
    end
    holdFor(SYNC_LAT + 4);
    checkResetState("no_strobe_unarmed");
    plan = '{7};
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 10; r++) begin
      int nInt;
      bit fr;
      bit fz;
      nInt = int'($urandom_range(1, 4));
      plan.delete();
      for (int i = 0; i < nInt; i++) plan.push_back(int'($urandom_range(2, 40)));
      fr = 1'($urandom_range(0, 1));
      fz = (plan[0] >= 3) && (($urandom_range(0, 2)) == 0);
      applyStimulus(fr, fz, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge i_clk);
    checkOutput("pending_strobes", longint'(sbq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/tick_interval_meter.md
# tick_interval_meter

Measures the time between consecutive rising edges of a tick input, the receive-side counterpart of the `timer` block. `timer` turns a configured period into `done` pulses; this block turns observed pulses back into a period, in clock cycles and in nanoseconds. It sits beside `timer` in the RPN calculator's timing infrastructure. It is used for self-checking the timer in-system and for measuring external periodic strobes.

## Interface
Parameters:
- `CLK_PERIOD_ns`, default 20: clock period in ns, used for the ns conversion.
- `COUNT_WIDTH`, default 24: width of the cycle counter and of `interval_cycles`.
- `NS_WIDTH`, default 32: width of `interval_ns`.

Ports:
- `clk`, input, 1: single clock; all logic is on its rising edge.
- `sync_reset`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: high = block runs; low = all state frozen.
- `arm`, input, 1: level. A rising edge starts a measurement. Holding it high gives free-run (back-to-back) measurement.
- `tick_in`, input, 1: the pulse train being measured.
- `busy`, output, 1: high while in WAIT_FIRST or MEASURE.
- `interval_valid`, output, 1: one-cycle strobe when a result is captured.
- `interval_cycles`, output, COUNT_WIDTH: measured interval in clock cycles.
- `interval_ns`, output, NS_WIDTH: `interval_cycles * CLK_PERIOD_ns`. Saturates to all-ones if the product exceeds NS_WIDTH.
- `overflow`, output, 1: set together with `interval_valid` when the interval exceeds the counter range.

## Operation
- Edge detect:
  - `tick_q` registers the (optionally synchronised) tick every cycle while enabled.
  - `edge = tick & ~tick_q`.
- States:
  - IDLE: `arm` high moves to WAIT_FIRST.
  - WAIT_FIRST: waits for the opening edge. On `edge`, clear `cnt` to 0 and move to MEASURE.
  - MEASURE: `cnt` increments every enabled cycle, saturating at all-ones. On `edge`:
    - capture `cnt+1` into `interval_cycles`, saturated at all-ones;
    - assert `interval_valid` for one cycle;
    - clear `cnt` to 0;
    - stay in MEASURE if `arm` is high, otherwise return to IDLE.
- Overflow: if `cnt` is all-ones when the closing edge arrives, `interval_cycles` is all-ones and `overflow` is high for that same strobe. There is no timeout; MEASURE waits indefinitely.
- `interval_cycles`, `interval_ns` and `overflow` hold their values until the next capture.
- `arm` dropping while in WAIT_FIRST or MEASURE does not abort. The measurement in progress completes, then the block returns to IDLE.
- `enable` low: state, `cnt` and `tick_q` are all frozen. An edge that arrives while disabled is never seen. On re-enable, an edge is detected only against the `tick_q` value held at freeze.
- `sync_reset` mid-measurement: the block returns to IDLE immediately and discards any partial count. `sync_reset` has priority over `enable`.

## Timing
- Reset values: state IDLE, `cnt`=0, `tick_q`=0, `busy`=0, `interval_valid`=0, `interval_cycles`=0, `interval_ns`=0, `overflow`=0.
- Ticks K cycles apart (rising edge to rising edge) measure as `interval_cycles`=K. The minimum measurable interval is 2 cycles.
- Result latency: `interval_valid` and the result outputs are registered. They update at the clock edge where the closing `edge` is sampled and are visible the following cycle.
- With the synchroniser compiled in, all edges are delayed 2 cycles. The measured interval is unchanged.
- `busy` rises the cycle after `arm` is sampled high in IDLE. It falls the same cycle `interval_valid` rises on the final (unarmed) capture.
- A closing edge in free-run is also the opening edge of the next interval; no tick is lost.

## Configuration
- `TICK_METER_SYNC_EN` defined: `tick_in` passes through a 2-flop synchroniser before edge detect, so it may be asynchronous to `clk`. Latency is +2 cycles.
- Not defined: `tick_in` must be synchronous to `clk` and goes straight to edge detect.

## Structure
- Shared package `timer_pkg` holds:
  - the state encoding constants (IDLE, WAIT_FIRST, MEASURE);
  - the ns-conversion saturation helper, shared with `timer`.
- Sub-module `tick_edge_detect` holds the optional synchroniser, `tick_q` and the `edge` output, with its own enable and reset. The FSM, counter and output registers stay in the top level.

## Test plan
All scenarios use `CLK_PERIOD_ns`=20.
- Single shot: `arm` pulsed 1 cycle, ticks 5 cycles apart. Expect `interval_cycles`=5, `interval_ns`=100, one `interval_valid`, `busy` back to 0.
- Free run: `arm` held, ticks at 100 ns spacing. Expect three consecutive strobes each with 5/100, no tick lost between measurements.
- Overflow: `COUNT_WIDTH`=4, ticks 20 cycles apart. Expect `interval_cycles`=15 and `overflow`=1 on the strobe.
- Enable freeze: `enable` low for 3 cycles mid-measurement with ticks 5 enabled cycles apart. Expect `interval_cycles`=5, and no edge detected on re-enable while `tick_in` is steady.
- Reset mid-measure: `sync_reset` asserted 2 cycles after the opening edge. Expect all outputs back to reset values next cycle and no strobe from later ticks until re-armed.
- Synchroniser: with `TICK_METER_SYNC_EN` defined, drive `tick_in` asynchronously with 100 ns period. Expect 5/100 with the strobe delayed 2 cycles relative to the unsynchronised build.
